// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Issues one request at a time to a 16-bit combinational ALU, owns
//            the Z/C flags, and runs a 16-iteration shift-add MUL on the adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int         WIDTH  = 16,
    parameter logic [4:0] MUL_OP = 5'd31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_skipped,
    output logic             rsp_illegal,
    output logic             flag_z,
    output logic             flag_c,
    input  logic             flags_we,
    input  logic [1:0]       flags_wdata,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    output logic             alu_enable,
    output logic             alu_zero_in,
    output logic             alu_carry_in,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_cond
);

    localparam logic [4:0] c_LAST_ALU_OP = 5'd27;
    localparam logic [4:0] c_MUL_ITERS   = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [4:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_skipped;
    logic             r_illegal;
    logic             r_flag_z;
    logic             r_flag_c;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [4:0]       r_cnt;
    logic             r_ovf;
    logic             r_mcand_lost;

    logic             w_is_alu_op;
    logic             w_is_mul_op;
    logic             w_mul_done;

    assign w_is_alu_op = (req_op <= c_LAST_ALU_OP);
    assign w_is_mul_op = (req_op == MUL_OP);
    assign w_mul_done  = (r_cnt == c_MUL_ITERS);

    assign req_ready    = (r_state == S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_result   = r_result;
    assign rsp_skipped  = r_skipped;
    assign rsp_illegal  = r_illegal;
    assign flag_z       = r_flag_z;
    assign flag_c       = r_flag_c;
    assign alu_zero_in  = r_flag_z;
    assign alu_carry_in = r_flag_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        alu_enable = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = 5'd0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_is_alu_op) begin
                        w_next = S_EXEC;
                    end else if (w_is_mul_op) begin
                        w_next = S_MUL;
                    end else begin
                        w_next = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                alu_enable = 1'b1;
                alu_a      = r_a;
                alu_b      = r_b;
                alu_op     = r_op;
                w_next     = S_RESP;
            end
            S_MUL: begin
                // One extra cycle after the 16th add latches the final accumulator.
                if (w_mul_done) begin
                    w_next = S_RESP;
                end else begin
                    alu_enable = 1'b1;
                    alu_a      = r_acc;
                    alu_b      = r_mplier[0] ? r_mcand : '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= 5'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_skipped    <= 1'b0;
            r_illegal    <= 1'b0;
            r_acc        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_cnt        <= 5'd0;
            r_ovf        <= 1'b0;
            r_mcand_lost <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op         <= req_op;
                        r_a          <= req_a;
                        r_b          <= req_b;
                        r_result     <= '0;
                        r_skipped    <= 1'b0;
                        r_illegal    <= !(w_is_alu_op || w_is_mul_op);
                        r_acc        <= '0;
                        r_mcand      <= req_a;
                        r_mplier     <= req_b;
                        r_cnt        <= 5'd0;
                        r_ovf        <= 1'b0;
                        r_mcand_lost <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (alu_cond) begin
                        r_result <= alu_out[WIDTH-1:0];
                    end else begin
                        r_skipped <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (w_mul_done) begin
                        r_result <= r_acc;
                    end else begin
                        // Overflow: adder carry, or adding a partial product whose
                        // upper bits were already shifted out of the multiplicand.
                        r_acc        <= alu_out[WIDTH-1:0];
                        r_ovf        <= r_ovf | alu_out[WIDTH] | (r_mplier[0] & r_mcand_lost);
                        r_mcand_lost <= r_mcand_lost | r_mcand[WIDTH-1];
                        r_mcand      <= r_mcand << 1;
                        r_mplier     <= r_mplier >> 1;
                        r_cnt        <= r_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (flags_we) begin
            r_flag_c <= flags_wdata[1];
            r_flag_z <= flags_wdata[0];
        end else if ((r_state == S_EXEC) && alu_cond) begin
            r_flag_z <= alu_zero;
            r_flag_c <= alu_carry;
        end else if ((r_state == S_MUL) && w_mul_done) begin
            r_flag_z <= (r_acc == '0);
            r_flag_c <= r_ovf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed self-checking bench for alu_sequencer with a small ALU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_skipped;
    logic        rsp_illegal;
    logic        flag_z;
    logic        flag_c;
    logic        flags_we;
    logic [1:0]  flags_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_op;
    logic        alu_enable;
    logic        alu_zero_in;
    logic        alu_carry_in;
    logic [16:0] alu_out;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_cond;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer #(.WIDTH(16), .MUL_OP(5'd31)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_skipped  (rsp_skipped),
        .rsp_illegal  (rsp_illegal),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flags_we     (flags_we),
        .flags_wdata  (flags_wdata),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_enable   (alu_enable),
        .alu_zero_in  (alu_zero_in),
        .alu_carry_in (alu_carry_in),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_cond     (alu_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal ALU: 0 add, 2 adc, op[4:2]==001 conditional-if-zero add.
    always_comb begin
        alu_out = {1'b0, alu_a} + {1'b0, alu_b};
        if (alu_op == 5'd2) begin
            alu_out = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_carry_in};
        end
        alu_zero  = (alu_out[15:0] == 16'd0);
        alu_carry = alu_out[16];
        alu_cond  = (alu_op[4:2] == 3'b001) ? alu_zero_in : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one request, measure latency, check the response, optionally hold it.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_z, input logic exp_c, input logic exp_skip,
                          input logic exp_ill, input int exp_lat, input bit we_in_exec,
                          input int hold);
        int lat;
        bit seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (lat == 1 && op <= 5'd27) begin
                check({tag, ".alu_enable"}, 32'(alu_enable), 32'd1);
            end
            if (we_in_exec && lat == 1) begin
                flags_we    = 1'b1;
                flags_wdata = 2'b10;
            end else begin
                flags_we = 1'b0;
            end
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        flags_we = 1'b0;
        check({tag, ".seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".result"}, 32'(rsp_result), 32'(exp_res));
        check({tag, ".z"}, 32'(flag_z), 32'(exp_z));
        check({tag, ".c"}, 32'(flag_c), 32'(exp_c));
        check({tag, ".skipped"}, 32'(rsp_skipped), 32'(exp_skip));
        check({tag, ".illegal"}, 32'(rsp_illegal), 32'(exp_ill));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_result"}, {15'd0, rsp_skipped, rsp_result}, {15'd0, exp_skip, exp_res});
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        bit seen;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = 5'd0;
        req_a       = 16'd0;
        req_b       = 16'd0;
        rsp_ready   = 1'b0;
        flags_we    = 1'b0;
        flags_wdata = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.result", 32'(rsp_result), 32'd0);
        check("rst.skip_ill", {30'd0, rsp_skipped, rsp_illegal}, 32'd0);
        check("rst.flags", {30'd0, flag_c, flag_z}, 32'd0);
        check("rst.alu_enable", 32'(alu_enable), 32'd0);

        //      tag      op    a        b        res      z  c  skip ill lat we hold
        run_op("add1",  5'd0, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 2,  0, 0);
        run_op("addov", 5'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0, 2,  0, 0);
        run_op("adc",   5'd2, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 0, 2,  0, 0);
        run_op("condz", 5'd4, 16'h0005, 16'h0006, 16'h0000, 0, 0, 1, 0, 2,  0, 5);
        run_op("mul1",  5'd31, 16'h0123, 16'h0010, 16'h1230, 0, 0, 0, 0, 18, 0, 0);
        run_op("mul2",  5'd31, 16'h8000, 16'h0002, 16'h0000, 1, 1, 0, 0, 18, 0, 0);
        run_op("illeg", 5'd29, 16'h1111, 16'h2222, 16'h0000, 1, 1, 0, 1, 1,  0, 0);
        run_op("fwe",   5'd0, 16'h0001, 16'h0002, 16'h0003, 0, 1, 0, 0, 2,  1, 0);

        // Abort a multiply with reset at its eighth iteration.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 5'd31;
        req_a     = 16'h0003;
        req_b     = 16'h0005;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort.req_ready", 32'(req_ready), 32'd1);
        check("abort.flags", {30'd0, flag_c, flag_z}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort.no_rsp", 32'(seen), 32'd0);

        run_op("fresh", 5'd0, 16'h0005, 16'h0006, 16'h000B, 0, 0, 0, 0, 2,  0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sits between the instruction decoder and the combinational 16-bit ALU.
- Accepts one operation at a time on a valid/ready request port and drives the ALU inputs.
- Owns the architectural zero and carry flag registers and returns results on a valid/ready response port.
- Adds a multicycle 16x16 MUL (low 16 bits of the product) that reuses the ALU adder over 16 iterations.

Parameters:
- WIDTH, 16, datapath width; the only supported value is 16.
- MUL_OP, 31, request opcode that selects the multicycle multiply.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  5  0..27 = ALU op codes; MUL_OP = multiply; other values are illegal
- req_a  in  16  operand A
- req_b  in  16  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  16  result
- rsp_skipped  out  1  condition not met; result invalid; flags unchanged
- rsp_illegal  out  1  illegal opcode
- flag_z  out  1  zero flag register
- flag_c  out  1  carry flag register
- flags_we  in  1  direct flag load (context restore)
- flags_wdata  in  2  {c,z} to load
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_op  out  5  ALU op
- alu_enable  out  1  ALU enable
- alu_zero_in  out  1  equals flag_z
- alu_carry_in  out  1  equals flag_c
- alu_out  in  17  ALU sum/result; bit 16 is carry
- alu_zero  in  1  ALU zero-flag output
- alu_carry  in  1  ALU carry-flag output
- alu_cond  in  1  ALU condition-met output

Behaviour:
- Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_skipped=0; rsp_illegal=0; flag_z=0; flag_c=0; alu_enable=0; MUL registers cleared.
- Reset mid-MUL or mid-RESP aborts the operation. No response is produced for it.
- States: IDLE, EXEC, MUL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/a/b.
  - Go to EXEC for op <= 27, MUL for op == MUL_OP, RESP with rsp_illegal=1 otherwise.
- EXEC (1 cycle):
  - alu_enable=1, alu_a/b/op driven from latched values.
  - If alu_cond=1: rsp_result=alu_out[15:0], flag_z<=alu_zero, flag_c<=alu_carry, rsp_skipped=0.
  - If alu_cond=0: rsp_skipped=1, flags held, rsp_result=0.
  - Always go to RESP.
- MUL:
  - On entry: acc=0, mcand=a, mplier=b, cnt=0, ovf=0.
  - Each cycle: alu_op=0 (add), alu_a=acc, alu_b = mplier[0] ? mcand : 0, alu_enable=1.
  - Same cycle: acc<=alu_out[15:0]; ovf<=ovf | alu_out[16] | (mplier[0] & mcand_shifted_out_bit).
  - Same cycle: mcand<=mcand<<1, mplier<=mplier>>1, cnt++.
  - After cnt=15 completes (16 cycles): rsp_result=acc, flag_z<=(acc==0), flag_c<=ovf (any bit lost above bit 15); go to RESP.
  - Early exit is not allowed; latency is fixed.
- RESP:
  - rsp_valid=1 with rsp_* outputs stable; req_ready=0.
  - On rsp_ready go to IDLE; rsp_valid drops next cycle.
- Latency:
  - ALU op accepted at cycle N gives rsp_valid at N+2.
  - MUL accepted at cycle N gives rsp_valid at N+18.
  - Throughput is one operation per 3 cycles minimum. Back-to-back acceptance is not supported while RESP is held.
- alu_enable=0 in IDLE and RESP. alu_a/b/op are don't-care there but driven to 0.
- flags_we:
  - Loads flag_c/flag_z next cycle in any state.
  - If it coincides with an EXEC or MUL completion flag update, flags_we wins.
- alu_zero_in/alu_carry_in always reflect the registered flags. Conditional and adc/sbc ops therefore see flags from the previous completed op.
- Flags never change on skipped or illegal ops.

Test Plan:
- Reset, then op 0 add a=0x0001 b=0x0002 -> rsp_result=0x0003, z=0, c=0, rsp_valid at N+2.
- Op 0 add a=0xFFFF b=0x0001 -> result 0x0000, z=1, c=1. Then op 2 (adc) a=0 b=0 -> result 0x0001, c=0.
- With z=0, issue a condition-if-zero op (op[4:2]=001) -> rsp_skipped=1, flags unchanged. Hold rsp_ready=0 for 5 cycles -> rsp_valid and outputs stable; req_ready=0.
- MUL a=0x0123 b=0x0010 -> result 0x1230, z=0, c=0, rsp_valid at N+18. MUL a=0x8000 b=0x0002 -> result 0, z=1, c=1.
- req_op=29 -> rsp_illegal=1, flags unchanged. flags_we={1,0} in the same cycle as an EXEC flag update -> c=1, z=0.
- Assert rst at MUL cycle 8 -> no rsp_valid; next cycle req_ready=1, flags=0. A fresh add completes normally.
